// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, driving the datapath and a req/ready memory port.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_MEMADDR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_R    = 4'd7,
    S_WB_MEM  = 4'd8,
    S_BRANCH  = 4'd9,
    S_LUI_EX  = 4'd10,
    S_WB_LUI  = 4'd11,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_rfunc_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | (w_next == S_TRAP);
    end
  end

  always_comb begin
    w_rfunc_ok = 1'b0;
    case (func)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110: w_rfunc_ok = 1'b1;
      default: w_rfunc_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALU_op     = ALU_ADD;
    instr_done = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        // PC+4 is computed and latched in the same cycle the fetch completes
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = 2'b01;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (op == 6'b000000 && w_rfunc_ok)        w_next = S_EXEC_R;
        else if (op == 6'b100011 || op == 6'b101011) w_next = S_MEMADDR;
        else if (op == 6'b000100)                 w_next = S_BRANCH;
        else if (op == 6'b001111)                 w_next = S_LUI_EX;
        else                                      w_next = S_TRAP;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        case (func)
          6'b100010: ALU_op = ALU_SUB;
          6'b100100: ALU_op = ALU_AND;
          6'b100101: ALU_op = ALU_OR;
          6'b100110: ALU_op = ALU_XOR;
          default:   ALU_op = ALU_ADD;
        endcase
        w_next = S_WB_R;
      end
      S_WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (op == 6'b101011) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALU_op     = ALU_SUB;
        PCSrc      = 1'b1;
        PCWrite    = zero;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_LUI_EX: begin
        ALUSrcB = 2'b10;
        ALU_op  = ALU_LUI;
        w_next  = S_WB_LUI;
      end
      S_WB_LUI: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  assign illegal = r_illegal;
  assign state   = r_state;

endmodule
